// File: rtl/module_secuenciador_pkg.sv
// Shared definitions for the calculator sequencer: FSM states, key codes and
// display-source encoding.
package pkg_calc;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CONV = 3'd2,
    S_MUL  = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_SIGN  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [1:0] DISP_A    = 2'd0;
  localparam logic [1:0] DISP_B    = 2'd1;
  localparam logic [1:0] DISP_PROD = 2'd2;
  localparam logic [1:0] DISP_ERR  = 2'd3;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] d;
    case (s)
      S_A:                d = DISP_A;
      S_B, S_CONV, S_MUL: d = DISP_B;
      S_SHOW:             d = DISP_PROD;
      default:            d = DISP_ERR;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/module_secuenciador_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// final allowed cycle so the caller can still let a same-cycle done win.
module module_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_r;

  // Cycle counter, saturating at the last allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = enable && (cnt_r == LAST);

endmodule

// File: rtl/module_secuenciador.sv
// Keypad-driven sequencer: collects two signed BCD operands, then launches
// conversion and multiplication under a watchdog. All outputs are registered.
module module_secuenciador
  import pkg_calc::*;
#(
  parameter int MAX_DIGITS  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       conv_done,
  input  logic       conv_error,
  input  logic       mul_done,
  output logic [7:0] num_a_bcd,
  output logic [7:0] num_b_bcd,
  output logic       a_neg,
  output logic       b_neg,
  output logic       conv_start,
  output logic       mul_start,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       err
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  state_t        state_r, nxt_state_s;
  logic [CW-1:0] cnt_a_r, cnt_b_r, nxt_cnt_a_s, nxt_cnt_b_s;
  logic [7:0]    nxt_a_s, nxt_b_s;
  logic          nxt_a_neg_s, nxt_b_neg_s, nxt_conv_start_s, nxt_mul_start_s;
  logic          key_digit_s, key_enter_s, key_sign_s, key_clear_s;
  logic          wd_clear_s, wd_enable_s, wd_timeout_s;

  assign key_digit_s = key_valid && is_digit(key_code);
  assign key_enter_s = key_valid && (key_code == KEY_ENTER);
  assign key_sign_s  = key_valid && (key_code == KEY_SIGN);
  assign key_clear_s = key_valid && (key_code == KEY_CLEAR);

  assign wd_enable_s = (state_r == S_CONV) || (state_r == S_MUL);
  assign wd_clear_s  = (nxt_state_s != state_r) &&
                       ((nxt_state_s == S_CONV) || (nxt_state_s == S_MUL));

  module_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .timeout (wd_timeout_s)
  );

  // Next-state and operand-entry decode; clear key overrides every state.
  always_comb begin
    nxt_state_s      = state_r;
    nxt_a_s          = num_a_bcd;
    nxt_b_s          = num_b_bcd;
    nxt_a_neg_s      = a_neg;
    nxt_b_neg_s      = b_neg;
    nxt_cnt_a_s      = cnt_a_r;
    nxt_cnt_b_s      = cnt_b_r;
    nxt_conv_start_s = 1'b0;
    nxt_mul_start_s  = 1'b0;
    if (key_clear_s) begin
      nxt_state_s = S_A;
      nxt_a_s     = 8'h00;
      nxt_b_s     = 8'h00;
      nxt_a_neg_s = 1'b0;
      nxt_b_neg_s = 1'b0;
      nxt_cnt_a_s = {CW{1'b0}};
      nxt_cnt_b_s = {CW{1'b0}};
    end else begin
      case (state_r)
        S_A: begin
          if (key_digit_s && (cnt_a_r < MAX_CNT)) begin
            nxt_a_s     = {num_a_bcd[3:0], key_code};
            nxt_cnt_a_s = cnt_a_r + CW'(1);
          end else if (key_sign_s) begin
            nxt_a_neg_s = ~a_neg;
          end else if (key_enter_s && (cnt_a_r != {CW{1'b0}})) begin
            nxt_state_s = S_B;
          end else begin
            nxt_state_s = S_A;
          end
        end
        S_B: begin
          if (key_digit_s && (cnt_b_r < MAX_CNT)) begin
            nxt_b_s     = {num_b_bcd[3:0], key_code};
            nxt_cnt_b_s = cnt_b_r + CW'(1);
          end else if (key_sign_s) begin
            nxt_b_neg_s = ~b_neg;
          end else if (key_enter_s && (cnt_b_r != {CW{1'b0}})) begin
            nxt_state_s      = S_CONV;
            nxt_conv_start_s = 1'b1;
          end else begin
            nxt_state_s = S_B;
          end
        end
        S_CONV: begin
          // A done arriving on the last watchdog cycle still wins.
          if (conv_done && !conv_error) begin
            nxt_state_s     = S_MUL;
            nxt_mul_start_s = 1'b1;
          end else if (conv_done || wd_timeout_s) begin
            nxt_state_s = S_ERR;
          end else begin
            nxt_state_s = S_CONV;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            nxt_state_s = S_SHOW;
          end else if (wd_timeout_s) begin
            nxt_state_s = S_ERR;
          end else begin
            nxt_state_s = S_MUL;
          end
        end
        S_SHOW: begin
          if (key_digit_s) begin
            nxt_state_s = S_A;
            nxt_a_s     = {4'h0, key_code};
            nxt_b_s     = 8'h00;
            nxt_a_neg_s = 1'b0;
            nxt_b_neg_s = 1'b0;
            nxt_cnt_a_s = CW'(1);
            nxt_cnt_b_s = {CW{1'b0}};
          end else begin
            nxt_state_s = S_SHOW;
          end
        end
        S_ERR:   nxt_state_s = S_ERR;
        default: nxt_state_s = S_ERR;
      endcase
    end
  end

  // State and output registers; status outputs follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_A;
      num_a_bcd  <= 8'h00;
      num_b_bcd  <= 8'h00;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
      cnt_a_r    <= {CW{1'b0}};
      cnt_b_r    <= {CW{1'b0}};
      conv_start <= 1'b0;
      mul_start  <= 1'b0;
      disp_sel   <= DISP_A;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      num_a_bcd  <= nxt_a_s;
      num_b_bcd  <= nxt_b_s;
      a_neg      <= nxt_a_neg_s;
      b_neg      <= nxt_b_neg_s;
      cnt_a_r    <= nxt_cnt_a_s;
      cnt_b_r    <= nxt_cnt_b_s;
      conv_start <= nxt_conv_start_s;
      mul_start  <= nxt_mul_start_s;
      disp_sel   <= disp_of(nxt_state_s);
      busy       <= (nxt_state_s == S_CONV) || (nxt_state_s == S_MUL);
      err        <= (nxt_state_s == S_ERR);
    end
  end

endmodule

// File: tb/tb_module_secuenciador.sv
// Scoreboard bench for module_secuenciador: a phase/digit-list reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_module_secuenciador;
  localparam int MAXD = 2;
  localparam int TO   = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       conv_done = 1'b0;
  logic       conv_error = 1'b0;
  logic       mul_done = 1'b0;
  logic [7:0] num_a_bcd, num_b_bcd;
  logic       a_neg, b_neg, conv_start, mul_start, busy, err;
  logic [1:0] disp_sel;

  module_secuenciador #(.MAX_DIGITS(MAXD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .conv_done(conv_done), .conv_error(conv_error), .mul_done(mul_done),
    .num_a_bcd(num_a_bcd), .num_b_bcd(num_b_bcd), .a_neg(a_neg), .b_neg(b_neg),
    .conv_start(conv_start), .mul_start(mul_start), .disp_sel(disp_sel),
    .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  // Reference model: phase 0 entering A, 1 entering B, 2 converting,
  // 3 multiplying, 4 showing product, 5 error.
  int   m_ph;
  int   m_da[$];
  int   m_db[$];
  logic m_an, m_bn, m_cs, m_ms;
  int   m_wait;

  logic [23:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic int digits_val(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  function automatic void m_reset();
    m_ph = 0; m_da.delete(); m_db.delete();
    m_an = 1'b0; m_bn = 1'b0; m_cs = 1'b0; m_ms = 1'b0; m_wait = 0;
  endfunction

  function automatic void m_step(input logic kv, input int kc, input logic cd,
                                 input logic ce, input logic md);
    m_cs = 1'b0; m_ms = 1'b0;
    if (kv && kc == 12) begin
      m_reset();
      return;
    end
    case (m_ph)
      0, 1: if (kv) begin
        if (kc <= 9) begin
          if (m_ph == 0 && m_da.size() < MAXD) m_da.push_back(kc);
          if (m_ph == 1 && m_db.size() < MAXD) m_db.push_back(kc);
        end else if (kc == 11) begin
          if (m_ph == 0) m_an = ~m_an; else m_bn = ~m_bn;
        end else if (kc == 10) begin
          if (m_ph == 0 && m_da.size() > 0) m_ph = 1;
          else if (m_ph == 1 && m_db.size() > 0) begin m_ph = 2; m_wait = 0; m_cs = 1'b1; end
        end
      end
      2: begin
        if (cd && !ce) begin m_ph = 3; m_wait = 0; m_ms = 1'b1; end
        else if (cd) m_ph = 5;
        else if (m_wait + 1 >= TO) m_ph = 5;
        else m_wait++;
      end
      3: begin
        if (md) m_ph = 4;
        else if (m_wait + 1 >= TO) m_ph = 5;
        else m_wait++;
      end
      4: if (kv && kc <= 9) begin m_reset(); m_da.push_back(kc); end
      default: ;
    endcase
  endfunction

  function automatic logic [23:0] m_out();
    logic [7:0] a, b;
    logic [1:0] ds;
    a = 8'(digits_val(m_da));
    b = 8'(digits_val(m_db));
    case (m_ph)
      0:       ds = 2'd0;
      1, 2, 3: ds = 2'd1;
      4:       ds = 2'd2;
      default: ds = 2'd3;
    endcase
    return {a, b, m_an, m_bn, m_cs, m_ms, ds, (m_ph == 2 || m_ph == 3), (m_ph == 5)};
  endfunction

  // Monitor: one expected snapshot per clock, compared just after the edge.
  initial begin
    logic [23:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {num_a_bcd, num_b_bcd, a_neg, b_neg, conv_start, mul_start, disp_sel, busy, err};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL outputs t=%0t got %h expected %h", $time, a, e);
        end
      end
    end
  end

  task automatic step(input logic kv, input logic [3:0] kc, input logic cd,
                      input logic ce, input logic md);
    @(negedge clk);
    rst = 1'b1; key_valid = kv; key_code = kc;
    conv_done = cd; conv_error = ce; mul_done = md;
    m_step(kv, int'(kc), cd, ce, md);
    exp_q.push_back(m_out());
  endtask

  task automatic press(input logic [3:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; conv_done = 1'b0; conv_error = 1'b0; mul_done = 1'b0;
    m_reset();
    exp_q.push_back(m_out());
  endtask

  task automatic enter_12_3();
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'hA);
  endtask

  initial begin
    logic [3:0] kc;
    do_reset(); do_reset();
    #1;
    if ({num_a_bcd, num_b_bcd, a_neg, b_neg, conv_start, mul_start, disp_sel, busy, err}
        !== 24'h000000) begin
      n_miss++;
      $display("FAIL reset state t=%0t a=%h b=%h an=%b bn=%b cs=%b ms=%b ds=%0d busy=%b err=%b",
               $time, num_a_bcd, num_b_bcd, a_neg, b_neg, conv_start, mul_start,
               disp_sel, busy, err);
    end
    // Full operation: 12 x 3
    enter_12_3();
    idle(1); step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(7); step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Digit limit and sign toggling
    press(4'hC); press(4'h4); press(4'h5); press(4'h6);
    press(4'hB); press(4'hB); press(4'hB); press(4'hE);
    // Enter on empty operand is ignored
    press(4'hC); press(4'hA); idle(2);
    // Conversion error, keys ignored in error, clear exits
    press(4'h7); press(4'hA); press(4'h8); press(4'hA);
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    press(4'h3); press(4'hA); press(4'hB); press(4'hC);
    // Multiplication timeout
    enter_12_3(); step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); idle(TO + 3);
    if (err !== 1'b1 || disp_sel !== 2'd3 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL expired wait t=%0t err=%b disp_sel=%0d busy=%b", $time, err, disp_sel, busy);
    end
    press(4'hC);
    // mul_done on the last allowed cycle wins over timeout
    enter_12_3(); step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    while (m_ph == 3 && m_wait < TO - 1) idle(1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); idle(2);
    // Digit in show starts a new operand A
    press(4'h9); press(4'hB); press(4'hA); press(4'hB); press(4'h4); press(4'hA);
    // Conversion timeout, then conv_done on the last allowed cycle
    idle(TO + 2); press(4'hC);
    enter_12_3();
    while (m_ph == 2 && m_wait < TO - 1) idle(1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    // Reset one cycle after mul_start, then quiet for 100 cycles
    idle(1); do_reset(); idle(100);
    // Clear during multiplication
    enter_12_3(); step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); idle(3); press(4'hC); idle(2);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      kc = 4'($urandom_range(0, 15));
      if (kc == 4'hC && $urandom_range(0, 5) != 0) kc = 4'hA;
      step(1'($urandom_range(0, 1)), kc, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
    end
    idle(2);
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss != 0) $display("FAIL %0d miscompares", n_miss);
    else $display("PASS");
    $finish;
  end

endmodule
